// File: rtl/main_control_fsm_pkg.sv
// main_control_fsm_pkg: opcodes, ALU/mux select encodings and controller state set
package main_control_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Shared with the downstream ALU control unit
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_e;

    function automatic logic is_legal(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_ADDI || op == OP_J;
    endfunction

endpackage

// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle main controller sequencing fetch/decode/execute/memory/writeback
module main_control_fsm
    import main_control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] ALUcontrol,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       illegal_op
);

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore decode; only FETCH's PC/IR loads look at mem_ready so each is loaded once
    always_comb begin
        ALUcontrol = ALU_ADD;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        PCSrc      = PC_ALU;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMM_SH;
                illegal_op = !is_legal(opcode);
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUcontrol = ALU_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUcontrol = ALU_SUB;
                PCSrc      = PC_ALUOUT;
                Branch     = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc   = PC_JUMP;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
